// File: rtl/counter_rtl_core_if.sv
// Bus bundle for the loadable up/down modulo counter: command inputs from the
// driver side and the registered count/status outputs back to it.
interface counter_rtl_core_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic             up_down;
  logic             enable;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             tc_up;
  logic             tc_down;
  logic             load_err;
  logic [7:0]       wrap_count;
  logic [1:0]       status;

  modport master (
    output load, up_down, enable, data_in,
    input  data_out, tc_up, tc_down, load_err, wrap_count, status
  );

  modport slave (
    input  load, up_down, enable, data_in,
    output data_out, tc_up, tc_down, load_err, wrap_count, status
  );
endinterface

// File: rtl/counter_rtl_core.sv
// Loadable up/down modulo counter over [MIN_VAL, MAX_VAL]. Every output is
// registered; the action taken at each edge is kept as a 4-state status FSM.
module counter_rtl_core #(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 11
) (
  input  logic               clock,
  input  logic               resetn,
  counter_rtl_core_if.slave  bus
);

  // Refuse to build with an empty or out-of-width count range.
  generate
    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= (2**WIDTH) - 1)) begin : g_bad_range
      $error("counter_rtl_core: illegal MIN_VAL/MAX_VAL for WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_LOAD = 2'd3
  } state_t;

  state_t           state, nxt_state;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             tc_up_q, tc_dn_q, err_q;
  logic             tc_up_nxt, tc_dn_nxt, err_nxt;
  logic [7:0]       wraps, wraps_nxt;
  logic             in_range;

  // Signed compare so a zero lower bound is not a constant-true test.
  assign in_range = (int'(bus.data_in) >= MIN_VAL) && (int'(bus.data_in) <= MAX_VAL);

  // Status state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_HOLD;
    else         state <= nxt_state;
  end

  // Next action is purely input-driven: load > enable > hold.
  always_comb begin
    nxt_state = ST_HOLD;
    if (bus.load)        nxt_state = ST_LOAD;
    else if (bus.enable) nxt_state = bus.up_down ? ST_UP : ST_DOWN;
  end

  // Status output is the action taken at the last edge.
  always_comb begin
    bus.status = state;
  end

  // Count/pulse next values; wrap test precedes the add so the count stays in range.
  always_comb begin
    cnt_nxt   = cnt;
    tc_up_nxt = 1'b0;
    tc_dn_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (nxt_state)
      ST_LOAD: begin
        if (in_range) cnt_nxt = bus.data_in;
        else          err_nxt = 1'b1;
      end
      ST_UP: begin
        if (cnt == MAX_V) begin
          cnt_nxt   = MIN_V;
          tc_up_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_DOWN: begin
        if (cnt == MIN_V) begin
          cnt_nxt   = MAX_V;
          tc_dn_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: ;
    endcase
    wraps_nxt = wraps;
    if ((tc_up_nxt || tc_dn_nxt) && (wraps != 8'hFF)) wraps_nxt = wraps + 8'd1;
  end

  // Count, pulse and saturating wrap-counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt     <= MIN_V;
      tc_up_q <= 1'b0;
      tc_dn_q <= 1'b0;
      err_q   <= 1'b0;
      wraps   <= 8'd0;
    end else begin
      cnt     <= cnt_nxt;
      tc_up_q <= tc_up_nxt;
      tc_dn_q <= tc_dn_nxt;
      err_q   <= err_nxt;
      wraps   <= wraps_nxt;
    end
  end

  assign bus.data_out   = cnt;
  assign bus.tc_up      = tc_up_q;
  assign bus.tc_down    = tc_dn_q;
  assign bus.load_err   = err_q;
  assign bus.wrap_count = wraps;

endmodule

// File: tb/tb_counter_rtl_core.sv
// Scoreboard bench for counter_rtl_core: stimulus pushes the reference-model
// prediction per edge, a monitor pops and compares at the following negedge.
module tb_counter_rtl_core;
  localparam int W    = 4;
  localparam int MINV = 0;
  localparam int MAXV = 11;
  localparam int SPAN = MAXV - MINV + 1;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  counter_rtl_core_if #(.WIDTH(W)) bus ();

  counter_rtl_core #(.WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct {
    int data;
    bit tcu;
    bit tcd;
    bit err;
    int wraps;
    int status;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   nstep = 0;

  // Reference model state: count value and raw (unsaturated) wrap tally.
  int m_cnt   = MINV;
  int m_wraps = 0;

  function automatic exp_t model_step(bit l, bit ud, bit en, int din);
    exp_t e;
    e.tcu = 0; e.tcd = 0; e.err = 0;
    if (l) begin
      e.status = 3;
      if (din >= MINV && din <= MAXV) m_cnt = din;
      else e.err = 1;
    end else if (en && ud) begin
      e.status = 1;
      e.tcu    = (m_cnt == MAXV);
      m_cnt    = MINV + ((m_cnt - MINV + 1) % SPAN);
    end else if (en) begin
      e.status = 2;
      e.tcd    = (m_cnt == MINV);
      m_cnt    = MINV + ((m_cnt - MINV - 1 + SPAN) % SPAN);
    end else begin
      e.status = 0;
    end
    if (e.tcu || e.tcd) m_wraps++;
    e.data  = m_cnt;
    e.wraps = (m_wraps > 255) ? 255 : m_wraps;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t g;
    g.data   = int'(bus.data_out);
    g.tcu    = bus.tc_up;
    g.tcd    = bus.tc_down;
    g.err    = bus.load_err;
    g.wraps  = int'(bus.wrap_count);
    g.status = int'(bus.status);
    return g;
  endfunction

  function automatic bit same(exp_t a, exp_t b);
    return a.data == b.data && a.tcu == b.tcu && a.tcd == b.tcd &&
           a.err == b.err && a.wraps == b.wraps && a.status == b.status;
  endfunction

  task automatic check(string name, exp_t g, exp_t e);
    total++;
    if (!same(g, e)) begin
      bad++;
      $display("FAIL %s: got data=%0d tcu=%0b tcd=%0b err=%0b wraps=%0d st=%0d, want data=%0d tcu=%0b tcd=%0b err=%0b wraps=%0d st=%0d",
               name, g.data, g.tcu, g.tcd, g.err, g.wraps, g.status,
               e.data, e.tcu, e.tcd, e.err, e.wraps, e.status);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.data = MINV; e.tcu = 0; e.tcd = 0; e.err = 0; e.wraps = 0; e.status = 0;
    return e;
  endfunction

  // One edge of stimulus; prediction is queued right after the edge it describes.
  task automatic step(bit l, bit ud, bit en, int din);
    exp_t e;
    bus.load    = l;
    bus.up_down = ud;
    bus.enable  = en;
    bus.data_in = W'(din);
    @(posedge clock);
    e = model_step(l, ud, en, din);
    sbq.push_back(e);
    nstep++;
    #1;
  endtask

  // Monitor: one registered result per edge, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check($sformatf("step%0d", nstep), sample(), e);
      end
    end
  end

  // Watchdog so a stuck run still reports.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.load = 0; bus.up_down = 0; bus.enable = 1; bus.data_in = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_hold", sample(), reset_exp());
    resetn = 1'b1;
    bus.enable = 0;
    @(posedge clock); #1;
    @(negedge clock);
    check("reset_release_hold", sample(), reset_exp());

    // Up wrap: 9,10,11,0,1
    step(1, 0, 0, 9);
    repeat (4) step(0, 1, 1, 0);
    // Down wrap: 1,0,11,10
    step(1, 0, 0, 1);
    repeat (3) step(0, 0, 1, 0);
    // Illegal load then legal load
    step(1, 0, 0, 5);
    step(1, 1, 1, 13);
    step(1, 0, 0, 4);
    step(0, 0, 0, 15);
    // Priority: load wins over enable, wrap on next count
    step(1, 1, 1, 11);
    step(0, 1, 1, 0);
    // Boundary loads give no pulse
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);

    // Async reset mid-cycle at count 7
    step(1, 0, 0, 7);
    @(negedge clock); #1;
    resetn = 1'b0;
    #1;
    check("async_reset", sample(), reset_exp());
    m_cnt = MINV; m_wraps = 0;
    bus.load = 0; bus.enable = 0;
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    check("after_async_reset", sample(), reset_exp());

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15));

    // Saturation: long continuous up-count
    for (int i = 0; i < 12 * 260; i++) step(0, 1, 1, 0);
    @(negedge clock); #1;
    total++;
    if (bus.wrap_count != 8'd255) begin
      bad++;
      $display("FAIL saturate: got wrap_count=%0d, want 255", bus.wrap_count);
    end

    // Drain, bounded.
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clock);
    #1;
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/counter_rtl_core.md
# counter_rtl_core

Synchronous loadable up/down modulo counter. This is the design under test that the counter verification environment drives and monitors. The write driver applies `load`, `up_down`, `enable` and `data_in`. The read monitor samples `data_out`, the terminal-count pulses, the load-error flag, the wrap counter and the action status. All outputs are registered, so the reference model predicts each cycle's result from the previous cycle's inputs.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `MIN_VAL`, default 0: lowest count value; the counter wraps to it when counting up.
- `MAX_VAL`, default 11: highest count value; the counter wraps to it when counting down. Legal range is MIN_VAL < MAX_VAL ≤ 2**WIDTH-1; elaboration fails otherwise.
- `clock`  in  1: single clock, rising edge.
- `resetn`  in  1: reset, asynchronous and active-low.
- `load`  in  1: load `data_in` on the next edge.
- `up_down`  in  1: direction; 1 = up, 0 = down.
- `enable`  in  1: count enable.
- `data_in`  in  WIDTH: load value.
- `data_out`  out  WIDTH: current count.
- `tc_up`  out  1: one-cycle pulse on an up-wrap MAX_VAL→MIN_VAL.
- `tc_down`  out  1: one-cycle pulse on a down-wrap MIN_VAL→MAX_VAL.
- `load_err`  out  1: one-cycle pulse when a load value is out of range.
- `wrap_count`  out  8: number of wraps in either direction, saturating.
- `status`  out  2: action taken at the last edge; 0 HOLD, 1 UP, 2 DOWN, 3 LOAD (LOAD is reported for both accepted and rejected loads).

## Operation
- Priority at each rising edge is reset > load > enable > hold.
- **Load, in range** (MIN_VAL ≤ data_in ≤ MAX_VAL): `data_out` ← `data_in`; `status` = LOAD; `load_err` = 0.
- **Load, out of range**: `data_out` holds; `load_err` = 1; `status` = LOAD.
- Load ignores `enable` and `up_down`.
- **Count up** (enable = 1, up_down = 1):
  - If data_out == MAX_VAL: `data_out` ← MIN_VAL and `tc_up` = 1.
  - Otherwise `data_out` increments by 1.
  - `status` = UP.
- **Count down** (enable = 1, up_down = 0):
  - If data_out == MIN_VAL: `data_out` ← MAX_VAL and `tc_down` = 1.
  - Otherwise `data_out` decrements by 1.
  - `status` = DOWN.
- **Hold** (load = 0, enable = 0): all state holds; `status` = HOLD; the three pulse outputs are 0.
- The `status` register is a 4-state machine. Its next state is a pure function of the inputs at the edge, so every state is reachable from every other in one cycle.
- **Arithmetic:**
  - Increment and decrement are WIDTH-bit.
  - The wrap test is done before the increment/decrement, so `data_out` never leaves [MIN_VAL, MAX_VAL].
  - The values 2**WIDTH-1 and 0 are reached only if they are the configured bounds.
- **wrap_count**: +1 on any edge where `tc_up` or `tc_down` is set. It saturates at 255 and never rolls over; only reset clears it.
- **Pulse outputs**: `tc_up`, `tc_down` and `load_err` are registered and cleared on every edge that does not set them.

## Timing
- **Reset values** (assert `resetn` low, asynchronous, immediate): `data_out` = MIN_VAL; `tc_up` = `tc_down` = `load_err` = 0; `wrap_count` = 0; `status` = HOLD.
- **Reset release**: synchronous use only; the first action occurs at the first rising edge with `resetn` = 1.
- **Latency**: one cycle. Inputs sampled at edge N appear on all outputs after edge N. There is no combinational input→output path.
- **Pulse alignment**: each pulse is high in the same cycle that `data_out` first shows the wrapped (or unchanged, for a rejected load) value.
- **Simultaneous load and enable**: load wins; no count and no tc pulse that cycle.
- **Load of the boundary value**: loading MAX_VAL (or MIN_VAL) gives no tc pulse. The wrap occurs on the next enabled count.
- **Reset mid-count or mid-pulse**: all outputs return to reset values immediately; a pulse is truncated.
- **Continuous enable**: back-to-back wraps are possible (e.g. MIN_VAL == MAX_VAL-1), with a pulse on each wrap cycle.

## Test plan
- **Reset**: hold resetn = 0 for 3 cycles, then release → data_out = 0, wrap_count = 0, status = 0, all pulses 0. Assert resetn asynchronously mid-cycle at count 7 → data_out = 0 before the next edge.
- **Up wrap**: load 9, then enable = 1, up_down = 1 for 4 cycles → data_out 9, 10, 11, 0, 1. tc_up = 1 only in the cycle showing 0; wrap_count = 1.
- **Down wrap**: load 1, then enable = 1, up_down = 0 for 3 cycles → data_out 1, 0, 11, 10. tc_down = 1 only in the cycle showing 11; status = 2.
- **Illegal load**: from count 5, load data_in = 13 → data_out stays 5, load_err = 1 for one cycle, status = 3. Then load 4 → data_out = 4, load_err = 0.
- **Priority**: load = 1, enable = 1, up_down = 1, data_in = 11 → data_out = 11, no tc_up. Next cycle, enable only → data_out = 0, tc_up = 1.
- **Saturation**: count up continuously for 12 × 260 cycles → wrap_count reaches 255 and stays 255; tc_up continues to pulse every 12 cycles.
